// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: round-robin fetch/loader arbiter that range-checks byte
// addresses and sequences fixed-latency accesses to a single-port instruction memory.
module imem_access_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
    parameter int          DEPTH      = 256,
    parameter int          RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    input  logic [31:0]              fetch_addr,
    output logic                     fetch_gnt,
    output logic                     fetch_valid,
    output logic [31:0]              fetch_instr,
    output logic                     fetch_err,
    input  logic                     ld_req,
    input  logic                     ld_we,
    input  logic [31:0]              ld_addr,
    input  logic [31:0]              ld_wdata,
    output logic                     ld_gnt,
    output logic                     ld_valid,
    output logic [31:0]              ld_rdata,
    output logic                     ld_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              fetch_count
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              is_ld_q, is_ld_d;
    logic              prefer_ld_q, prefer_ld_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [31:0]       fetch_instr_q, fetch_instr_d;
    logic              fetch_err_q, fetch_err_d;
    logic              ld_valid_q, ld_valid_d;
    logic [31:0]       ld_rdata_q, ld_rdata_d;
    logic              ld_err_q, ld_err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic [31:0]       sel_addr, off;
    logic              addr_ok;

    // Grants are combinational in IDLE and forced low while reset is asserted.
    assign fetch_gnt = rst_n && state_q == IDLE && fetch_req && (!ld_req || !prefer_ld_q);
    assign ld_gnt    = rst_n && state_q == IDLE && ld_req && (!fetch_req || prefer_ld_q);
    assign sel_addr  = ld_gnt ? ld_addr : fetch_addr;
    assign off       = sel_addr - BASE_ADDR;
    assign addr_ok   = sel_addr[1:0] == 2'b00 && sel_addr >= BASE_ADDR && off < SPAN;

    always_comb begin
        state_d       = state_q;
        is_ld_d       = is_ld_q;
        prefer_ld_d   = prefer_ld_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = '0;
        fetch_err_d   = 1'b0;
        ld_valid_d    = 1'b0;
        ld_rdata_d    = '0;
        ld_err_d      = 1'b0;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        case (state_q)
            IDLE: if (fetch_gnt || ld_gnt) begin
                is_ld_d     = ld_gnt;
                prefer_ld_d = fetch_gnt;
                mem_addr_d  = off[AW+1:2];
                mem_wdata_d = ld_gnt ? ld_wdata : '0;
                if (addr_ok) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    mem_we_d = ld_gnt && ld_we;
                end else begin
                    state_d       = RESP;
                    fetch_valid_d = fetch_gnt;
                    fetch_err_d   = fetch_gnt;
                    ld_valid_d    = ld_gnt;
                    ld_err_d      = ld_gnt;
                end
            end
            ISSUE: if (mem_we_q) begin
                state_d       = RESP;
                fetch_valid_d = !is_ld_q;
                ld_valid_d    = is_ld_q;
            end else begin
                state_d = WAIT;
                cnt_d   = 3'(RD_LATENCY - 1);
            end
            WAIT: if (cnt_q == '0) begin
                state_d       = RESP;
                fetch_valid_d = !is_ld_q;
                fetch_instr_d = is_ld_q ? '0 : mem_rdata;
                ld_valid_d    = is_ld_q;
                ld_rdata_d    = is_ld_q ? mem_rdata : '0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
        // Count lands in the same cycle the good fetch response becomes visible.
        fetch_count_d = (fetch_valid_d && !fetch_err_d && fetch_count_q != '1) ? fetch_count_q + 32'd1 : fetch_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            is_ld_q       <= 1'b0;
            prefer_ld_q   <= 1'b0;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            fetch_err_q   <= 1'b0;
            ld_valid_q    <= 1'b0;
            ld_rdata_q    <= '0;
            ld_err_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            is_ld_q       <= is_ld_d;
            prefer_ld_q   <= prefer_ld_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_err_q   <= fetch_err_d;
            ld_valid_q    <= ld_valid_d;
            ld_rdata_q    <= ld_rdata_d;
            ld_err_q      <= ld_err_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_err   = fetch_err_q;
    assign ld_valid    = ld_valid_q;
    assign ld_rdata    = ld_rdata_q;
    assign ld_err      = ld_err_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb_imem_access_arbiter: directed + random transactions checked against a
// transaction-level model of arbitration, address checking, latency and data.
module tb_imem_access_arbiter;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 256;
    localparam int          RDL   = 1;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        fetch_req = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
    logic [31:0] fetch_addr = '0, ld_addr = '0, ld_wdata = '0;
    logic        fetch_gnt, fetch_valid, fetch_err, ld_gnt, ld_valid, ld_err, mem_en, mem_we;
    logic [31:0] fetch_instr, ld_rdata, mem_wdata, fetch_count;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  mem_addr;

    imem_access_arbiter #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return i == 0 ? 32'h2008_0005 : (i * 32'h9E37_79B9) ^ 32'h0000_1234;
    endfunction

    // Memory array seen by the DUT; preloaded while reset is held.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  en_cnt = 0, en_cyc = 0, gnt_busy = 0;
    int  we_addr = -1;
    bit  busy = 0;
    always @(negedge clk) begin
        if (!rst_n) busy = 0;
        if (busy && (fetch_gnt || ld_gnt)) gnt_busy++;
        if (fetch_valid || ld_valid) busy = 0;
        if (fetch_gnt || ld_gnt) busy = 1;
        if (mem_en) begin
            en_cnt++;
            en_cyc = cyc;
            if (mem_we) we_addr = int'(mem_addr);
        end
    end

    int          total = 0, bad = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_cnt;
    bit          last_ld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        exp_cnt = '0;
        last_ld = 1'b1;
    endtask

    task automatic txn(input bit ld, input bit we, input logic [31:0] a, input logic [31:0] wd);
        int g, lat, e0, idx, exp_lat;
        bit ok;
        logic [31:0] exp_d;
        ok = a[1:0] == 2'b00 && longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 4 * DEPTH;
        idx = ok ? int'((a - BASE) / 4) : 0;
        exp_lat = !ok ? 1 : (ld && we) ? 2 : RDL + 2;
        exp_d = (!ok || (ld && we)) ? 32'h0 : ref_mem[idx];
        @(posedge clk); #1;
        if (ld) begin ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = wd; end
        else begin fetch_req = 1; fetch_addr = a; end
        e0 = en_cnt;
        @(negedge clk);
        g = cyc;
        chk("gnt", {30'b0, fetch_gnt, ld_gnt}, ld ? 32'd1 : 32'd2);
        last_ld = ld;
        @(posedge clk); #1;
        fetch_req = 0; ld_req = 0;
        fetch_addr = $urandom; ld_addr = $urandom; ld_wdata = $urandom; ld_we = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (fetch_valid || ld_valid) lat = k;
        end
        chk("latency", lat, exp_lat);
        chk("valid_src", {30'b0, fetch_valid, ld_valid}, ld ? 32'd1 : 32'd2);
        chk("data", ld ? ld_rdata : fetch_instr, exp_d);
        chk("err", ld ? ld_err : fetch_err, 32'(!ok));
        chk("mem_en_cnt", en_cnt - e0, 32'(ok));
        if (ok) chk("mem_en_cyc", en_cyc - g, 1);
        if (ld && we && ok) begin
            chk("mem_we_addr", we_addr, idx);
            ref_mem[idx] = wd;
        end
        if (!ld && ok && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        chk("count", fetch_count, exp_cnt);
    endtask

    initial begin
        bit got;
        int pulses;
        logic [31:0] a;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(|{fetch_gnt, fetch_valid, fetch_instr, fetch_err, ld_gnt, ld_valid, ld_rdata,
                               ld_err, mem_en, mem_we, mem_addr, mem_wdata, fetch_count}), 0);
        rst_n = 1;

        txn(0, 0, BASE, 0);

        // Both requesters held high across three arbitration rounds.
        @(posedge clk); #1;
        fetch_req = 1; fetch_addr = BASE + 32; ld_req = 1; ld_we = 0; ld_addr = BASE + 64;
        for (int r = 0; r < 3; r++) begin
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (fetch_gnt || ld_gnt) got = 1;
            end
            chk("arb_gnt_seen", 32'(got), 1);
            chk("arb_one_gnt", 32'(fetch_gnt && ld_gnt), 0);
            chk("arb_winner", 32'(ld_gnt), 32'(!last_ld));
            last_ld = ld_gnt;
            if (!ld_gnt && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
            if (r == 2) begin @(posedge clk); #1; fetch_req = 0; ld_req = 0; end
        end
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (fetch_valid || ld_valid) got = 1;
        end
        chk("arb_last_done", 32'(got), 1);
        chk("arb_count", fetch_count, exp_cnt);

        txn(1, 1, BASE + 16, 32'hDEAD_BEEF);
        txn(0, 0, BASE + 16, 0);
        txn(0, 0, BASE + 2, 0);
        txn(0, 0, BASE + 4 * DEPTH, 0);
        txn(1, 0, BASE - 4, 0);
        txn(1, 1, BASE + 4 * DEPTH + 4, 32'h1111_2222);
        txn(0, 0, BASE + 4 * DEPTH - 4, 0);
        txn(1, 0, BASE + 16, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = BASE + 4 * $urandom_range(0, DEPTH - 1);
                2:       a = BASE + $urandom_range(0, 4 * DEPTH - 1);
                default: a = $urandom;
            endcase
            txn(1'($urandom), 1'($urandom), a, $urandom);
        end

        // Reset asserted while a read sits in its wait cycle.
        @(posedge clk); #1;
        fetch_req = 1; fetch_addr = BASE + 12;
        @(negedge clk);
        chk("rst_pre_gnt", 32'(fetch_gnt), 1);
        @(posedge clk); #1;
        fetch_req = 0;
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        chk("rst_mid_outs", 32'(|{fetch_gnt, fetch_valid, fetch_instr, fetch_err, ld_gnt, ld_valid, ld_rdata,
                                 ld_err, mem_en, mem_we, mem_addr, mem_wdata, fetch_count}), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (fetch_valid || ld_valid) pulses++;
        end
        chk("rst_no_pulse", pulses, 0);
        txn(0, 0, BASE + 8, 0);

        // Saturation of the completed-fetch counter.
        @(posedge clk); #1;
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;
        exp_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("sat_preset", fetch_count, exp_cnt);
        txn(0, 0, BASE + 4, 0);
        txn(0, 0, BASE + 8, 0);
        txn(0, 0, BASE + 12, 0);
        chk("sat_final", fetch_count, 32'hFFFF_FFFF);

        chk("gnt_while_busy", gnt_busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
